// File: rtl/fifo_native2aurora.sv
// Drains a native FIFO (rd_en/data_out/empty) into the Aurora TX AXI-Stream port through a 2-entry skid buffer.
// Optional frame marking: define NATIVE2AURORA_TLAST_EN to add s_axis_tlast every PKT_BEATS beats.
module fifo_native2aurora #(
  parameter int DATA_WIDTH = 256,
  parameter int PKT_BEATS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  channel_up,
  input  logic                  fifo_empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  s_axis_tvalid,
  output logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tready,
`ifdef NATIVE2AURORA_TLAST_EN
  output logic                  s_axis_tlast,
`endif
  output logic [31:0]           tx_count
);

  logic [1:0]            count;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;
  logic [2:0]            credit;

  assign pop    = s_axis_tvalid && s_axis_tready;
  // Entries held plus the word already requested, minus the one leaving now.
  assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en  = !rst && channel_up && !fifo_empty && (credit < 3'd2);

  assign s_axis_tvalid = (count != 2'd0);
  assign s_axis_tdata  = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= rd_en;
      case ({inflight, pop})
        2'b10: begin
          if (count == 2'd0) head <= data_out;
          else               tail <= data_out;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Capture and pop together: count is unchanged, the new word lands behind the survivor.
          if (count == 2'd2) begin
            head <= tail;
            tail <= data_out;
          end else begin
            head <= data_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      tx_count <= 32'd0;
    else if (pop) tx_count <= tx_count + 32'd1;
  end

`ifdef NATIVE2AURORA_TLAST_EN
  localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_BEATS - 1);

  logic [BW-1:0] beat_cnt;

  // Advances only on accepted beats, so frames survive backpressure and link drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
      else                       beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign s_axis_tlast = s_axis_tvalid && (beat_cnt == LAST_BEAT);
`endif

endmodule

// File: tb/tb_fifo_native2aurora.sv
// Directed bench for fifo_native2aurora: behavioural native FIFO, beat monitor and per-scenario checks.
module tb_fifo_native2aurora;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          channel_up = 1'b0;
  logic          fifo_empty;
  logic          rd_en;
  logic [DW-1:0] data_out = '0;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tready = 1'b0;
  logic [31:0]   tx_count;
`ifdef NATIVE2AURORA_TLAST_EN
  logic          s_axis_tlast;
`endif

  fifo_native2aurora #(.DATA_WIDTH(DW), .PKT_BEATS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .channel_up    (channel_up),
    .fifo_empty    (fifo_empty),
    .rd_en         (rd_en),
    .data_out      (data_out),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
`ifdef NATIVE2AURORA_TLAST_EN
    .s_axis_tlast  (s_axis_tlast),
`endif
    .tx_count      (tx_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural native FIFO with one-cycle read latency.
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  initial begin
    forever begin
      @(posedge clk);
      if (rd_en) begin
        data_out <= mem[rd_ptr % 64];
        rd_ptr   <= rd_ptr + 1;
      end
    end
  end

  // Monitor: accepted beats plus invariant violations.
  logic [DW-1:0] rx_q [$];
  int            rx_cyc [$];
  bit            rx_last [$];
  int            cyc = 0;
  int            outstanding = 0;
  int            viol = 0;
  int            rd_total = 0;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_data = '0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        outstanding = 0;
        prev_hold   = 0;
      end else begin
        if (rd_en && fifo_empty) viol++;
        if (prev_hold && (!s_axis_tvalid || s_axis_tdata !== prev_data)) viol++;
        if (s_axis_tvalid && s_axis_tready) begin
          rx_q.push_back(s_axis_tdata);
          rx_cyc.push_back(cyc);
`ifdef NATIVE2AURORA_TLAST_EN
          rx_last.push_back(s_axis_tlast);
`else
          rx_last.push_back(1'b0);
`endif
        end
        outstanding += int'(rd_en) - int'(s_axis_tvalid && s_axis_tready);
        if (outstanding > 2 || outstanding < 0) viol++;
        if (rd_en) rd_total++;
        prev_hold = s_axis_tvalid && !s_axis_tready;
        prev_data = s_axis_tdata;
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] v);
    mem[wr_ptr % 64] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
    rx_last.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    channel_up = 1'b1;
    s_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tvalid got=%b exp=0", s_axis_tvalid); end
    n_checks++;
    if (s_axis_tdata !== '0) begin n_fail++; $display("[TB] FAIL reset_tdata got=%h exp=0", s_axis_tdata); end
    n_checks++;
    if (tx_count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_tx_count got=%0d exp=0", tx_count); end
    push_word({32{8'hEE}});
    #1;
    n_checks++;
    if (rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_en got=%b exp=0", rd_en); end
    wr_ptr = wr_ptr - 1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    w = {32{8'hA5}};
    clear_rx();
    s_axis_tready = 1'b1;
    push_word(w);
    #1;
    n_checks++;
    if (rd_en !== 1'b1) begin n_fail++; $display("[TB] FAIL single_rd_en_c0 got=%b exp=1", rd_en); end
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b0 || s_axis_tvalid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL single_c1 rd_en=%b tvalid=%b exp 0/0", rd_en, s_axis_tvalid);
    end
    @(negedge clk);
    n_checks++;
    if (s_axis_tvalid !== 1'b1 || s_axis_tdata !== w) begin
      n_fail++; $display("[TB] FAIL single_c2 tvalid=%b tdata=%h exp 1/%h", s_axis_tvalid, s_axis_tdata, w);
    end
    @(negedge clk);
    n_checks++;
    if (s_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_c3_tvalid got=%b exp=0", s_axis_tvalid); end
    n_checks++;
    if (tx_count !== 32'd1) begin n_fail++; $display("[TB] FAIL single_tx_count got=%0d exp=1", tx_count); end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== w) begin
      n_fail++; $display("[TB] FAIL single_rx size=%0d exp=1", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int gaps;
    int bad;
    clear_rx();
    s_axis_tready = 1'b1;
    for (int i = 1; i <= 16; i++) push_word(DW'(i));
    for (int c = 0; c < 100 && rx_q.size() < 16; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 16) begin n_fail++; $display("[TB] FAIL b2b_count got=%0d exp=16", rx_q.size()); end
    gaps = 0;
    bad  = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i] !== DW'(i + 1)) bad++;
      if (i > 0 && rx_cyc[i] - rx_cyc[i-1] != 1) gaps++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("[TB] FAIL b2b_order bad_words=%0d exp=0", bad); end
    n_checks++;
    if (gaps != 0) begin n_fail++; $display("[TB] FAIL b2b_gaps got=%0d exp=0", gaps); end
    n_checks++;
    if (tx_count !== 32'd17) begin n_fail++; $display("[TB] FAIL b2b_tx_count got=%0d exp=17", tx_count); end
  endtask

  task automatic test_backpressure();
    int bad;
    int v0;
    v0 = viol;
    clear_rx();
    s_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(DW'(32'h100 + i));
    for (int c = 0; c < 200 && rx_q.size() < 16; c++) begin
      @(negedge clk);
      s_axis_tready = ~s_axis_tready;
    end
    s_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 16) begin n_fail++; $display("[TB] FAIL bp_count got=%0d exp=16", rx_q.size()); end
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== DW'(32'h100 + i)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("[TB] FAIL bp_order bad_words=%0d exp=0", bad); end
    n_checks++;
    if (viol != v0) begin n_fail++; $display("[TB] FAIL bp_invariants violations=%0d exp=0", viol - v0); end
    n_checks++;
    if (tx_count !== 32'd33) begin n_fail++; $display("[TB] FAIL bp_tx_count got=%0d exp=33", tx_count); end
  endtask

  task automatic test_link_drop();
    int base;
    int rd_down;
    int tv_low;
    int bad;
    clear_rx();
    s_axis_tready = 1'b1;
    base = rd_total;
    for (int i = 0; i < 10; i++) push_word(DW'(32'h200 + i));
    for (int c = 0; c < 50 && rd_total - base < 4; c++) @(negedge clk);
    channel_up = 1'b0;
    s_axis_tready = 1'b0;
    rd_down = 0;
    tv_low  = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rd_en !== 1'b0) rd_down++;
      if (s_axis_tvalid !== 1'b1) tv_low++;
      @(negedge clk);
    end
    n_checks++;
    if (rd_down != 0) begin n_fail++; $display("[TB] FAIL link_rd_en_while_down cycles=%0d exp=0", rd_down); end
    n_checks++;
    if (tv_low != 0) begin n_fail++; $display("[TB] FAIL link_tvalid_dropped cycles=%0d exp=0", tv_low); end
    channel_up = 1'b1;
    s_axis_tready = 1'b1;
    for (int c = 0; c < 100 && rx_q.size() < 10; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 10) begin n_fail++; $display("[TB] FAIL link_count got=%0d exp=10", rx_q.size()); end
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== DW'(32'h200 + i)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("[TB] FAIL link_order bad_words=%0d exp=0", bad); end
    n_checks++;
    if (tx_count !== 32'd43) begin n_fail++; $display("[TB] FAIL link_tx_count got=%0d exp=43", tx_count); end
  endtask

  task automatic test_reset_midflight();
    int bad;
    clear_rx();
    s_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(DW'(32'h300 + i));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rd_en got=%b exp=0", rd_en); end
    @(negedge clk);
    n_checks++;
    if (s_axis_tvalid !== 1'b0 || tx_count !== 32'd0) begin
      n_fail++; $display("[TB] FAIL midrst_state tvalid=%b tx_count=%0d exp 0/0", s_axis_tvalid, tx_count);
    end
    rst = 1'b0;
    s_axis_tready = 1'b1;
    clear_rx();
    for (int c = 0; c < 50 && rx_q.size() < 3; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 3) begin n_fail++; $display("[TB] FAIL midrst_count got=%0d exp=3", rx_q.size()); end
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== DW'(32'h302 + i)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("[TB] FAIL midrst_order bad_words=%0d exp=0", bad); end
    n_checks++;
    if (tx_count !== 32'd3) begin n_fail++; $display("[TB] FAIL midrst_tx_count got=%0d exp=3", tx_count); end
  endtask

`ifdef NATIVE2AURORA_TLAST_EN
  task automatic test_tlast();
    int bad;
    s_axis_tready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_rx();
    for (int i = 0; i < 12; i++) push_word(DW'(32'h400 + i));
    for (int c = 0; c < 300 && rx_q.size() < 12; c++) begin
      @(negedge clk);
      s_axis_tready = 1'($urandom_range(0, 1));
    end
    s_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 12) begin n_fail++; $display("[TB] FAIL tlast_count got=%0d exp=12", rx_q.size()); end
    bad = 0;
    for (int i = 0; i < rx_last.size(); i++)
      if (rx_last[i] != ((i % 4) == 3)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("[TB] FAIL tlast_pattern bad_beats=%0d exp=0", bad); end
  endtask
`endif

  task automatic test_invariants();
    n_checks++;
    if (viol != 0) begin n_fail++; $display("[TB] FAIL invariants violations=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_link_drop();
    test_reset_midflight();
`ifdef NATIVE2AURORA_TLAST_EN
    test_tlast();
`endif
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
